// File: rtl/dmx_pkg.sv
// dmx_pkg: shared helpers for the dot-matrix scroller (row select, sprite placement, widths)
package dmx_pkg;
  localparam int MAX_W = 64;
  function automatic int cnt_w(input int div);
    return div > 1 ? $clog2(div) : 1;
  endfunction
  function automatic int pos_max(input int wrap, input int cols, input int spr_w);
    return wrap != 0 ? cols - 1 : cols - spr_w;
  endfunction
  function automatic logic [MAX_W-1:0] row_sel(input int idx, input int rows);
    logic [MAX_W-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_W; i++) w[i] = (i < rows) && (i != rows - 1 - idx);
    return w;
  endfunction
  function automatic logic [MAX_W-1:0] place(input logic [MAX_W-1:0] bits, input int pos, input int cols, input int spr_w);
    logic [MAX_W-1:0] w;
    w = '0;
    for (int j = 0; j < MAX_W; j++) if (j < spr_w) w[(pos + j) % cols] = bits[j];
    return w;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running modulo-DIV counter with a one-cycle tick at terminal count
module tick_gen import dmx_pkg::*; #(
  parameter int DIV = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   o_tick,
  output logic [cnt_w(DIV)-1:0]  o_cnt
);
  logic [cnt_w(DIV)-1:0] r_cnt;
  assign o_tick = r_cnt == cnt_w(DIV)'(DIV - 1);
  assign o_cnt  = r_cnt;
  // count up, wrapping to zero after the terminal count
  always_ff @(posedge clk) r_cnt <= (rst || o_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/dot_matrix_scroller.sv
// dot_matrix_scroller: row-scanned LED matrix driver showing a button/auto-scrolled sprite
module dot_matrix_scroller import dmx_pkg::*; #(
  parameter int ROWS     = 8,
  parameter int COLS     = 16,
  parameter int SPR_W    = 8,
  parameter int SCAN_DIV = 2500,
  parameter int KEY_DIV  = 6250000,
  parameter int BLANK    = 4,
  parameter int WRAP     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ROWS*SPR_W-1:0]    sprite,
  input  logic                     l_sig,
  input  logic                     r_sig,
  input  logic                     auto_en,
  output logic [ROWS-1:0]          row,
  output logic [COLS-1:0]          col,
  output logic [$clog2(COLS)-1:0]  pos,
  output logic                     frame_start
);
  localparam int RW    = $clog2(ROWS);
  localparam int POS_W = $clog2(COLS);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(pos_max(WRAP, COLS, SPR_W));
  logic                         w_scan_tick, w_key_tick, w_frame, w_blank, w_up, w_dn;
  logic [cnt_w(SCAN_DIV)-1:0]   w_scan_cnt;
  logic [cnt_w(KEY_DIV)-1:0]    w_unused_key_cnt;
  logic [SPR_W-1:0]             w_spr_row;
  logic [POS_W-1:0]             w_disp, w_pos_inc, w_pos_dec;
  logic [ROWS-1:0]              w_row, r_row;
  logic [COLS-1:0]              w_col, r_col;
  logic [RW-1:0]                r_row_idx;
  logic [POS_W-1:0]             r_pos, r_pos_disp;
  logic                         r_frame;
  tick_gen #(.DIV(SCAN_DIV)) u_scan (.clk(clk), .rst(rst), .o_tick(w_scan_tick), .o_cnt(w_scan_cnt));
  tick_gen #(.DIV(KEY_DIV))  u_key  (.clk(clk), .rst(rst), .o_tick(w_key_tick),  .o_cnt(w_unused_key_cnt));
  assign w_frame   = w_scan_cnt == '0 && r_row_idx == '0;
  assign w_disp    = w_frame ? r_pos : r_pos_disp;
  assign w_blank   = int'(w_scan_cnt) < BLANK;
  assign w_spr_row = sprite[r_row_idx*SPR_W +: SPR_W];
  assign w_row     = ROWS'(row_sel(int'(r_row_idx), ROWS));
  assign w_col     = COLS'(place(MAX_W'(w_spr_row), int'(w_disp), COLS, SPR_W));
  assign w_up      = (r_sig & ~l_sig) | (~r_sig & ~l_sig & auto_en);
  assign w_dn      = l_sig & ~r_sig;
  assign w_pos_inc = r_pos == POS_MAX ? (WRAP != 0 ? '0 : POS_MAX) : r_pos + 1'b1;
  assign w_pos_dec = r_pos == '0 ? (WRAP != 0 ? POS_MAX : '0) : r_pos - 1'b1;
  // advance the scanned row, step the position on key ticks and register the pin drive
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_idx  <= '0;
      r_pos      <= '0;
      r_pos_disp <= '0;
      r_row      <= '1;
      r_col      <= '0;
      r_frame    <= 1'b0;
    end else begin
      if (w_scan_tick) r_row_idx <= r_row_idx == RW'(ROWS - 1) ? '0 : r_row_idx + 1'b1;
      if (w_key_tick) r_pos <= w_up ? w_pos_inc : w_dn ? w_pos_dec : r_pos;
      r_pos_disp <= w_disp;
      r_row      <= w_blank ? '1 : w_row;
      r_col      <= w_blank ? '0 : w_col;
      r_frame    <= w_frame;
    end
  end
  assign row         = r_row;
  assign col         = r_col;
  assign pos         = r_pos;
  assign frame_start = r_frame;
endmodule

// File: tb/tb_dot_matrix_scroller.sv
// tb_dot_matrix_scroller: directed scoreboard bench for the wrapping and saturating scroller
module tb_dot_matrix_scroller;
  logic        clk = 1'b0, rst = 1'b1, l_sig = 1'b0, r_sig = 1'b0, auto_en = 1'b0;
  logic [63:0] sprite = 64'h99423CF00FA5811C;
  logic [7:0]  row, row2;
  logic [15:0] col, col2;
  logic [3:0]  pos, pos2;
  logic        fs, fs2;
  int          n = 0, errors = 0, checks = 0;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t sb[$];
  dot_matrix_scroller #(.ROWS(8), .COLS(16), .SPR_W(8), .SCAN_DIV(10), .KEY_DIV(100), .BLANK(2), .WRAP(1)) dut (
    .clk(clk), .rst(rst), .sprite(sprite), .l_sig(l_sig), .r_sig(r_sig), .auto_en(auto_en),
    .row(row), .col(col), .pos(pos), .frame_start(fs));
  dot_matrix_scroller #(.ROWS(8), .COLS(16), .SPR_W(8), .SCAN_DIV(10), .KEY_DIV(100), .BLANK(2), .WRAP(0)) dut_sat (
    .clk(clk), .rst(rst), .sprite(sprite), .l_sig(l_sig), .r_sig(r_sig), .auto_en(auto_en),
    .row(row2), .col(col2), .pos(pos2), .frame_start(fs2));
  always #5 clk = ~clk;
  always @(posedge clk) n <= rst ? 0 : n + 1;
  task automatic ex(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic at(input int t);
    int g = 0;
    while (n < t && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (n != t) begin
      checks++;
      errors++;
      $error("FAIL cycle_sync observed=%0d expected=%0d", n, t);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    ex("rst_row", 32'hFF); ex("rst_col", 0); ex("rst_pos", 0); ex("rst_fs", 0); ex("rst_row_sat", 32'hFF);
    chk(32'(row)); chk(32'(col)); chk(32'(pos)); chk(32'(fs)); chk(32'(row2));
    rst = 1'b0;
    ex("blank0_fs", 1); ex("blank0_row", 32'hFF); ex("blank0_col", 0);
    at(1); chk(32'(fs)); chk(32'(row)); chk(32'(col));
    ex("blank1_row", 32'hFF); ex("blank1_fs", 0);
    at(2); chk(32'(row)); chk(32'(fs));
    ex("row0_sel", 32'h7F); ex("row0_col", 32'h001C);
    at(3); chk(32'(row)); chk(32'(col));
    ex("row1_sel", 32'hBF); ex("row1_col", 32'h0081);
    at(13); chk(32'(row)); chk(32'(col));
    ex("fs_pre", 0);
    at(80); chk(32'(fs));
    ex("fs_period", 1);
    at(81); chk(32'(fs));
    ex("fs_post", 0);
    at(82); chk(32'(fs));
    r_sig = 1'b1;
    ex("right_1", 1);
    at(100); chk(32'(pos));
    ex("right_3", 3);
    at(300); chk(32'(pos));
    r_sig = 1'b0; l_sig = 1'b1;
    ex("old_frame_row", 32'hFE); ex("old_frame_col", 32'h0264);
    at(313); chk(32'(row)); chk(32'(col));
    ex("new_frame_row", 32'h7F); ex("new_frame_col", 32'h00E0);
    at(323); chk(32'(row)); chk(32'(col));
    ex("left_to_0", 0);
    at(600); chk(32'(pos));
    ex("left_wrap", 15); ex("sat_low_clamp", 0);
    at(700); chk(32'(pos)); chk(32'(pos2));
    l_sig = 1'b0; sprite[7:0] = 8'h07;
    ex("wrap_col", 32'h8003);
    at(723); chk(32'(col));
    r_sig = 1'b1;
    ex("right_wrap", 0);
    at(800); chk(32'(pos));
    l_sig = 1'b1; auto_en = 1'b1;
    ex("both_hold", 0); ex("both_hold_sat", 1);
    at(900); chk(32'(pos)); chk(32'(pos2));
    r_sig = 1'b0; l_sig = 1'b0;
    ex("auto_1", 1);
    at(1000); chk(32'(pos));
    ex("auto_2", 2); ex("auto_sat", 3);
    at(1100); chk(32'(pos)); chk(32'(pos2));
    auto_en = 1'b0;
    at(1176);
    rst = 1'b1;
    @(posedge clk);
    #1;
    ex("midrst_row", 32'hFF); ex("midrst_col", 0); ex("midrst_pos", 0); ex("midrst_fs", 0);
    chk(32'(row)); chk(32'(col)); chk(32'(pos)); chk(32'(fs));
    rst = 1'b0;
    ex("restart_fs", 1);
    at(1); chk(32'(fs));
    ex("restart_row", 32'h7F); ex("restart_col", 32'h0007);
    at(3); chk(32'(row)); chk(32'(col));
    r_sig = 1'b1;
    ex("sat_reach", 8); ex("wrap_8", 8);
    at(800); chk(32'(pos2)); chk(32'(pos));
    ex("sat_col", 32'h0700);
    at(883); chk(32'(col2));
    ex("sat_hold", 8); ex("wrap_9", 9);
    at(900); chk(32'(pos2)); chk(32'(pos));
    ex("sat_20", 8); ex("wrap_20", 4);
    at(2000); chk(32'(pos2)); chk(32'(pos));
    r_sig = 1'b0; l_sig = 1'b1;
    ex("sat_left_1", 7); ex("wrap_left_1", 3);
    at(2100); chk(32'(pos2)); chk(32'(pos));
    ex("sat_left_0", 0); ex("wrap_left_8", 12);
    at(2800); chk(32'(pos2)); chk(32'(pos));
    ex("sat_left_stay", 0); ex("wrap_left_20", 0);
    at(4000); chk(32'(pos2)); chk(32'(pos));
    l_sig = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
